btn_cmd_gen: RTL and testbench

Front-end button conditioner that produces the command interface consumed by the stopwatch/game-control blocks. It supplies a periodic sampling strobe `clk_en_d` and a per-button command vector `inst`. Each physical press is debounced and yields exactly one `inst` bit that is high during exactly one `clk_en_d` cycle. It sits between the board pushbuttons and every block that acts on `clk_en_d && inst[k]`.

---
 rtl/btn_cmd_gen.sv | 142 ++++++++++++++
 tb/tb_btn_cmd_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/btn_cmd_gen.sv
// Pushbutton front end: synchronizes, debounces and turns each press
// into a single-period command bit aligned with the sampling strobe.
module btn_cmd_gen #(
  parameter int N_BTN    = 4,
  parameter int EN_DIV   = 500000,
  parameter int DB_TICKS = 4,
  parameter int CNT_W    = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic             clk_en_d,
  output logic [N_BTN-1:0] inst,
  output logic [N_BTN-1:0] btn_level
);

  localparam int DBC_W = $clog2(DB_TICKS + 1);
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DB_TICKS);
  localparam logic [DBC_W-1:0] DBC_ONE  = DBC_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM,
    HELD,
    RELEASE
  } state_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] btn_sync;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [N_BTN-1:0] evt;

  state_t           state_q [N_BTN];
  state_t           state_d [N_BTN];
  logic [DBC_W-1:0] dbc_q   [N_BTN];
  logic [DBC_W-1:0] dbc_d   [N_BTN];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      btn_sync <= '0;
    end else begin
      sync1    <= btn_raw;
      btn_sync <= sync1;
    end
  end

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      clk_en_d <= 1'b0;
    end else begin
      cnt      <= tick ? '0 : cnt + CNT_W'(1);
      clk_en_d <= tick;
    end
  end

  // Debounce FSMs only move on sampling ticks; otherwise they hold.
  always_comb begin
    for (int k = 0; k < N_BTN; k++) begin
      state_d[k] = state_q[k];
      dbc_d[k]   = dbc_q[k];
      evt[k]     = 1'b0;
      if (tick) begin
        case (state_q[k])
          IDLE: begin
            if (btn_sync[k]) begin
              if (DB_TICKS == 1) begin
                state_d[k] = HELD;
                evt[k]     = 1'b1;
              end else begin
                state_d[k] = CONFIRM;
                dbc_d[k]   = DBC_ONE;
              end
            end
          end
          CONFIRM: begin
            if (!btn_sync[k]) begin
              state_d[k] = IDLE;
              dbc_d[k]   = '0;
            end else if (dbc_q[k] + DBC_ONE == DBC_LAST) begin
              state_d[k] = HELD;
              dbc_d[k]   = '0;
              evt[k]     = 1'b1;
            end else begin
              dbc_d[k] = dbc_q[k] + DBC_ONE;
            end
          end
          HELD: begin
            if (!btn_sync[k]) begin
              if (DB_TICKS == 1) begin
                state_d[k] = IDLE;
              end else begin
                state_d[k] = RELEASE;
                dbc_d[k]   = DBC_ONE;
              end
            end
          end
          RELEASE: begin
            if (btn_sync[k]) begin
              state_d[k] = HELD;
              dbc_d[k]   = '0;
            end else if (dbc_q[k] + DBC_ONE == DBC_LAST) begin
              state_d[k] = IDLE;
              dbc_d[k]   = '0;
            end else begin
              dbc_d[k] = dbc_q[k] + DBC_ONE;
            end
          end
          default: begin
            state_d[k] = IDLE;
            dbc_d[k]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst      <= '0;
      btn_level <= '0;
      for (int k = 0; k < N_BTN; k++) begin
        state_q[k] <= IDLE;
        dbc_q[k]   <= '0;
      end
    end else begin
      if (tick) inst <= evt;
      for (int k = 0; k < N_BTN; k++) begin
        state_q[k]   <= state_d[k];
        dbc_q[k]     <= dbc_d[k];
        btn_level[k] <= (state_d[k] == HELD) ||
                        (state_d[k] == RELEASE);
      end
    end
  end

endmodule

// File: tb/tb_btn_cmd_gen.sv
// Directed bench for btn_cmd_gen with N_BTN=2, EN_DIV=4, DB_TICKS=3.
// Expected cycles are hand-derived from the 2-flop sync and tick at cnt==3.
module tb_btn_cmd_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn_raw = 2'b00;
  logic       clk_en_d;
  logic [1:0] inst;
  logic [1:0] btn_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int presses [2];

  btn_cmd_gen #(
    .N_BTN(2),
    .EN_DIV(4),
    .DB_TICKS(3),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .clk_en_d(clk_en_d),
    .inst(inst),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic logic strobe(input int c);
    return (c > 0) && (c % 4 == 0);
  endfunction

  function automatic logic in_win(input int c);
    return (c >= 12) && (c <= 15);
  endfunction

  // Values seen at this negedge are those sampled at posedge cyc.
  task automatic adv();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++)
      if (clk_en_d && inst[k]) presses[k]++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    presses[0] = 0;
    presses[1] = 0;
  endtask

  initial begin
    // reset state and free-running strobe
    btn_raw = 2'b00;
    do_reset();
    check("rst_en", clk_en_d, 0);
    check("rst_inst", inst, 0);
    check("rst_lvl", btn_level, 0);
    while (cyc < 17) begin
      adv();
      check("t1_en", clk_en_d, strobe(cyc));
      check("t1_inst", inst, 0);
      check("t1_lvl", btn_level, 0);
    end

    // clean press, held
    do_reset();
    btn_raw = 2'b01;
    while (cyc < 40) begin
      adv();
      check("t2_en", clk_en_d, strobe(cyc));
      check("t2_inst0", inst[0], in_win(cyc));
      check("t2_inst1", inst[1], 0);
      check("t2_lvl0", btn_level[0], cyc >= 12);
    end
    check("t2_presses", presses[0], 1);

    // release with a bounce back high
    while (cyc < 72) begin
      btn_raw[0] = (cyc >= 45) && (cyc < 50);
      adv();
      check("t4_inst0", inst[0], 0);
      check("t4_lvl0", btn_level[0], cyc < 64);
    end
    check("t4_presses", presses[0], 1);

    // bouncing press
    do_reset();
    while (cyc < 41) begin
      btn_raw = {1'b0, (cyc >= 20) || ((cyc / 3) % 2 == 0)};
      adv();
      check("t3_inst0", inst[0], (cyc >= 32) && (cyc <= 35));
      check("t3_inst1", inst[1], 0);
      check("t3_lvl0", btn_level[0], cyc >= 32);
    end
    check("t3_presses0", presses[0], 1);
    check("t3_presses1", presses[1], 0);

    // simultaneous press
    do_reset();
    btn_raw = 2'b11;
    while (cyc < 24) begin
      adv();
      check("t5_inst", inst, in_win(cyc) ? 2'b11 : 2'b00);
      check("t5_lvl", btn_level, (cyc >= 12) ? 2'b11 : 2'b00);
    end
    check("t5_presses0", presses[0], 1);
    check("t5_presses1", presses[1], 1);

    // reset after two high ticks, button still held
    do_reset();
    btn_raw = 2'b10;
    while (cyc < 9) begin
      adv();
      check("t6_pre_inst", inst, 0);
      check("t6_pre_lvl", btn_level, 0);
    end
    check("t6_pre_presses", presses[1], 0);
    do_reset();
    check("t6_rst_inst", inst, 0);
    while (cyc < 20) begin
      adv();
      check("t6_inst1", inst[1], in_win(cyc));
      check("t6_lvl1", btn_level[1], cyc >= 12);
      check("t6_inst0", inst[0], 0);
    end
    check("t6_presses", presses[1], 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
